// File: rtl/osc_freq_monitor.sv
// rtl/osc_freq_monitor.sv - oscillator frequency window and loss-of-clock monitor
//
// Counts rising edges of the asynchronous MON_CLK over a gate window of
// GATE_CYCLES CLK cycles, reports the count and whether it lies within
// [MIN_COUNT, MAX_COUNT], keeps a sticky error flag, and optionally flags
// loss of the monitored clock.
//
// Optional feature macro: OSC_MON_LOSS_DET_EN (loss-of-clock detector).
//
// Ports:
//   CLK          in   monitor clock
//   RESETN       in   synchronous active-low reset
//   ENABLE       in   run measurements while high
//   MON_CLK      in   monitored oscillator, asynchronous to CLK
//   ERR_CLR      in   one-cycle pulse, clears FREQ_ERR
//   COUNT        out  edge count of the last completed window
//   COUNT_VALID  out  one-cycle pulse when COUNT updates
//   FREQ_OK      out  last completed window was in range
//   FREQ_ERR     out  sticky out-of-range flag
//   CLK_LOSS     out  no monitored edge for LOSS_LIMIT cycles
module osc_freq_monitor #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned MIN_COUNT   = 990,
  parameter int unsigned MAX_COUNT   = 1010,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOSS_LIMIT  = 200
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             ENABLE,
  input  logic             MON_CLK,
  input  logic             ERR_CLR,
  output logic [CNT_W-1:0] COUNT,
  output logic             COUNT_VALID,
  output logic             FREQ_OK,
  output logic             FREQ_ERR,
  output logic             CLK_LOSS
);

  localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              hist_q, hist_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              count_valid_q, count_valid_d;
  logic              freq_ok_q, freq_ok_d;
  logic              freq_err_q, freq_err_d;

  logic              edge_pulse;
  logic              in_range;

  always_comb begin
    edge_pulse    = sync2_q & ~hist_q;
    // The saturated value is always above MAX_COUNT, so saturation reads as out of range.
    in_range      = (edge_cnt_q >= MIN_C) && (edge_cnt_q <= MAX_C);

    sync1_d       = MON_CLK;
    sync2_d       = sync1_q;
    hist_d        = sync2_q;

    state_d       = state_q;
    gate_d        = gate_q;
    edge_cnt_d    = edge_cnt_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    freq_ok_d     = freq_ok_q;
    freq_err_d    = ERR_CLR ? 1'b0 : freq_err_q;

    unique case (state_q)
      IDLE: begin
        gate_d     = '0;
        edge_cnt_d = '0;
        if (ENABLE) begin
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (!ENABLE) begin
          // Abort discards the partial window; reported results are left untouched.
          state_d    = IDLE;
          gate_d     = '0;
          edge_cnt_d = '0;
        end else begin
          if (edge_pulse && (edge_cnt_q != CNT_SAT)) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
          if (gate_q == GATE_LAST) begin
            gate_d  = '0;
            state_d = EVAL;
          end else begin
            gate_d = gate_q + GATE_W'(1);
          end
        end
      end

      EVAL: begin
        count_d       = edge_cnt_q;
        count_valid_d = 1'b1;
        freq_ok_d     = in_range;
        // Setting takes priority over a coincident ERR_CLR.
        if (!in_range) begin
          freq_err_d = 1'b1;
        end
        gate_d = '0;
        if (ENABLE) begin
          // An edge arriving during evaluation belongs to the next window.
          state_d    = MEASURE;
          edge_cnt_d = CNT_W'(edge_pulse);
        end else begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hist_q        <= 1'b0;
      gate_q        <= '0;
      edge_cnt_q    <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      freq_ok_q     <= 1'b0;
      freq_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      freq_ok_q     <= freq_ok_d;
      freq_err_q    <= freq_err_d;
    end
  end

  assign COUNT       = count_q;
  assign COUNT_VALID = count_valid_q;
  assign FREQ_OK     = freq_ok_q;
  assign FREQ_ERR    = freq_err_q;

`ifdef OSC_MON_LOSS_DET_EN
  localparam int unsigned       LOSS_W   = $clog2(LOSS_LIMIT + 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_LIMIT);

  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (!ENABLE || edge_pulse) begin
      loss_cnt_d = '0;
    end else if (loss_cnt_q != LOSS_MAX) begin
      loss_cnt_d = loss_cnt_q + LOSS_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign CLK_LOSS = (loss_cnt_q == LOSS_MAX);
`else
  logic unused_loss_limit;
  assign unused_loss_limit = |LOSS_LIMIT;
  assign CLK_LOSS          = 1'b0;
`endif

endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb/tb_osc_freq_monitor.sv - randomized self-checking bench for osc_freq_monitor
module tb_osc_freq_monitor;

  localparam int G    = 1000;
  localparam int MINC = 19;
  localparam int MAXC = 21;
  localparam int CW   = 8;
  localparam int LL   = 200;
  localparam int SAT  = 255;
`ifdef OSC_MON_LOSS_DET_EN
  localparam bit LOSS_ON = 1'b1;
`else
  localparam bit LOSS_ON = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          resetn  = 1'b0;
  logic          enable  = 1'b0;
  logic          mon_clk = 1'b0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          freq_ok;
  logic          freq_err;
  logic          clk_loss;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mon_period = 0;
  int mon_ph     = 0;

  // Reference model state: sampled MON_CLK history, window deadline and tallies.
  logic          h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic          p_now, set_err;
  bit            active  = 1'b0;
  int            eval_at = 0;
  int            win     = 0;
  int            anchor  = 0;
  int            c;
  logic [CW-1:0] e_count = '0;
  logic          e_valid = 1'b0, e_ok = 1'b0, e_err = 1'b0, e_loss = 1'b0;

  osc_freq_monitor #(
    .GATE_CYCLES(G),
    .MIN_COUNT  (MINC),
    .MAX_COUNT  (MAXC),
    .CNT_W      (CW),
    .LOSS_LIMIT (LL)
  ) dut (
    .CLK        (clk),
    .RESETN     (resetn),
    .ENABLE     (enable),
    .MON_CLK    (mon_clk),
    .ERR_CLR    (err_clr),
    .COUNT      (count),
    .COUNT_VALID(count_valid),
    .FREQ_OK    (freq_ok),
    .FREQ_ERR   (freq_err),
    .CLK_LOSS   (clk_loss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitored oscillator: period in CLK cycles, roughly half high; 0 holds it low.
  initial forever begin
    @(negedge clk);
    if (mon_period < 2) begin
      mon_clk = 1'b0;
      mon_ph  = 0;
    end else begin
      mon_ph  = (mon_ph + 1) % mon_period;
      mon_clk = (mon_ph < mon_period / 2);
    end
  end

  // Reference model: an edge is seen two clocks after MON_CLK is first sampled high;
  // a window reports min(edges, SAT) at its deadline edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      active = 1'b0; win = 0; eval_at = 0; anchor = cyc;
      e_count = '0; e_valid = 1'b0; e_ok = 1'b0; e_err = 1'b0;
    end else begin
      p_now   = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = mon_clk;
      e_valid = 1'b0;
      set_err = 1'b0;
      if (active && cyc == eval_at) begin
        c       = (win > SAT) ? SAT : win;
        e_count = CW'(c);
        e_valid = 1'b1;
        e_ok    = (c >= MINC) && (c <= MAXC);
        set_err = !e_ok;
        if (enable) begin
          eval_at = cyc + G + 1;
          win     = int'(p_now);
        end else begin
          active = 1'b0;
        end
      end else if (active) begin
        if (!enable) active = 1'b0;
        else win += int'(p_now);
      end else if (enable) begin
        active  = 1'b1;
        eval_at = cyc + G + 1;
        win     = 0;
      end
      e_err = set_err ? 1'b1 : (err_clr ? 1'b0 : e_err);
      if (!enable || p_now) anchor = cyc;
    end
    e_loss = LOSS_ON && ((cyc - anchor) >= LL);
    #1;
    check("count_valid", count_valid, e_valid);
    check("count", count, e_count);
    check("freq_ok", freq_ok, e_ok);
    check("freq_err", freq_err, e_err);
    check("clk_loss", clk_loss, e_loss);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit);
    int k = 0;
    while (k < limit) begin
      @(negedge clk);
      if (count_valid) return;
      k++;
    end
    check("valid_timeout", count_valid, 1);
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_count", count, 0);
    check("rst_valid", count_valid, 0);
    check("rst_ok", freq_ok, 0);
    check("rst_err", freq_err, 0);
    check("rst_loss", clk_loss, 0);
    resetn = 1'b1;

    // Nominal 50-cycle period.
    mon_period = 50;
    enable     = 1'b1;
    repeat (3) wait_valid(3000);
    check("nom_ok", freq_ok, 1);
    check("nom_err", freq_err, 0);

    // Fast oscillator, then recover and clear.
    mon_period = 40;
    repeat (2) wait_valid(3000);
    check("fast_ok", freq_ok, 0);
    check("fast_err", freq_err, 1);
    mon_period = 50;
    wait_valid(3000);
    tick($urandom_range(10, 500));
    pulse_clr();
    repeat (2) wait_valid(3000);
    check("clr_err", freq_err, 0);

    // Oscillator stops, then restarts.
    mon_period = 0;
    tick(1500);
    check("loss_held", clk_loss, LOSS_ON);
    wait_valid(3000);
    mon_period = 50;
    repeat (2) wait_valid(3000);

    // Abort mid-window and re-enable.
    wait_valid(3000);
    tick(500);
    enable = 1'b0;
    tick($urandom_range(1, 20));
    enable = 1'b1;
    repeat (2) wait_valid(3000);

    // Saturation at period 2.
    mon_period = 2;
    repeat (2) wait_valid(3000);
    check("sat_count", count, SAT);
    check("sat_ok", freq_ok, 0);
    check("sat_err", freq_err, 1);

    // ERR_CLR on the same edge as an out-of-range evaluation.
    wait_cyc(eval_at - 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_at_eval", count_valid, 1);
    check("set_wins", freq_err, 1);

    // Reset mid-window while the error flag is set.
    tick(400);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst_count", count, 0);
    check("mrst_err", freq_err, 0);
    check("mrst_ok", freq_ok, 0);
    check("mrst_loss", clk_loss, 0);
    resetn = 1'b1;

    // Randomized segments.
    for (int i = 0; i < 8; i++) begin
      int dur;
      int r;
      dur = $urandom_range(300, 2500);
      r   = $urandom_range(0, 5);
      mon_period = (r == 0) ? 0 : (r == 1) ? 2 : int'($urandom_range(30, 70));
      for (int k = 0; k < dur; k++) begin
        @(negedge clk);
        err_clr = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 999) == 0) enable = ~enable;
        resetn = ($urandom_range(0, 4999) != 0);
      end
      err_clr = 1'b0;
      resetn  = 1'b1;
      enable  = 1'b1;
    end
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
